// File: rtl/usb_rst_sequencer.sv
// Turns the software USB reset level into a timed reset sequence for the
// external host controller: minimum low pulse, settle window, ready flag.
module usb_rst_sequencer #(
  parameter int PULSE_CYCLES  = 50,
  parameter int SETTLE_CYCLES = 100000,
  parameter int CNT_W         = 20,
  parameter int RCNT_W        = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rst_req,
  input  logic              usb_irq_n,
  output logic              usb_rst_n,
  output logic              usb_ready,
  output logic              busy,
  output logic              irq_out,
  output logic [RCNT_W-1:0] reset_cnt
);

  typedef enum logic [1:0] {
    ASSERT  = 2'd0,
    RECOVER = 2'd1,
    READY   = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] PULSE_LAST  = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;

  // Outputs are assigned alongside every state change so they always
  // describe the state being entered on this edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ASSERT;
      cnt       <= '0;
      usb_rst_n <= 1'b0;
      usb_ready <= 1'b0;
      busy      <= 1'b1;
      irq_out   <= 1'b0;
      reset_cnt <= '0;
    end else begin
      case (state)
        ASSERT: begin
          irq_out <= 1'b0;
          if (cnt == PULSE_LAST && !rst_req) begin
            state     <= RECOVER;
            cnt       <= '0;
            usb_rst_n <= 1'b1;
          end else if (cnt != PULSE_LAST) begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        RECOVER: begin
          if (rst_req) begin
            state     <= ASSERT;
            cnt       <= '0;
            usb_rst_n <= 1'b0;
            irq_out   <= 1'b0;
          end else if (cnt == SETTLE_LAST) begin
            state     <= READY;
            cnt       <= '0;
            usb_ready <= 1'b1;
            busy      <= 1'b0;
            irq_out   <= ~usb_irq_n;
            reset_cnt <= reset_cnt + RCNT_W'(1);
          end else begin
            cnt     <= cnt + CNT_W'(1);
            irq_out <= 1'b0;
          end
        end
        READY: begin
          if (rst_req) begin
            state     <= ASSERT;
            cnt       <= '0;
            usb_rst_n <= 1'b0;
            usb_ready <= 1'b0;
            busy      <= 1'b1;
            irq_out   <= 1'b0;
          end else begin
            irq_out <= ~usb_irq_n;
          end
        end
        default: begin
          // Unused encoding: fall back to a fresh reset pulse.
          state     <= ASSERT;
          cnt       <= '0;
          usb_rst_n <= 1'b0;
          usb_ready <= 1'b0;
          busy      <= 1'b1;
          irq_out   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_usb_rst_sequencer.sv
// Bench for usb_rst_sequencer: timestamp-based reference model compared every
// cycle, plus directed literal checks and randomized request traffic.
module tb_usb_rst_sequencer;
  localparam int P = 4;
  localparam int S = 8;

  logic       clk = 1'b0;
  logic       reset, rst_req, usb_irq_n;
  logic       usb_rst_n, usb_ready, busy, irq_out;
  logic [7:0] reset_cnt;

  int tests = 0;
  int fails = 0;

  usb_rst_sequencer #(.PULSE_CYCLES(P), .SETTLE_CYCLES(S), .CNT_W(20), .RCNT_W(8)) dut (
    .clk(clk), .reset(reset), .rst_req(rst_req), .usb_irq_n(usb_irq_n),
    .usb_rst_n(usb_rst_n), .usb_ready(usb_ready), .busy(busy),
    .irq_out(irq_out), .reset_cnt(reset_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: tracks the edge index at which the pin last fell / rose.
  int       n = 0;
  int       t_fall = 0, t_rise = 0;
  bit       m_valid = 0, m_low = 1, m_ready = 0, m_irq = 0;
  bit [7:0] m_rcnt = 0;

  always @(posedge clk) begin
    n++;
    if (reset) begin
      m_valid = 1; m_low = 1; m_ready = 0; t_fall = n; m_rcnt = 0; m_irq = 0;
    end else if (m_valid) begin
      if (m_low) begin
        if (n - t_fall >= P && !rst_req) begin m_low = 0; t_rise = n; end
      end else if (!m_ready) begin
        if (rst_req) begin m_low = 1; t_fall = n; end
        else if (n - t_rise >= S) begin m_ready = 1; m_rcnt++; end
      end else if (rst_req) begin
        m_low = 1; m_ready = 0; t_fall = n;
      end
      m_irq = m_ready & ~usb_irq_n;
    end
    #1;
    if (m_valid) begin
      chk("cmp_usb_rst_n", usb_rst_n, !m_low);
      chk("cmp_usb_ready", usb_ready, m_ready);
      chk("cmp_busy", busy, !m_ready);
      chk("cmp_irq_out", irq_out, m_irq);
      chk("cmp_reset_cnt", reset_cnt, m_rcnt);
    end
  end

  task automatic step(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic wait_ready(input int bound, output int cyc);
    cyc = 0;
    while (!usb_ready && cyc < bound) begin
      @(negedge clk);
      cyc++;
    end
    if (!usb_ready) chk("ready_timeout", usb_ready, 1);
  endtask

  task automatic wait_rise(input int bound, output int cyc);
    cyc = 0;
    while (!usb_rst_n && cyc < bound) begin
      @(negedge clk);
      cyc++;
    end
    if (!usb_rst_n) chk("rise_timeout", usb_rst_n, 1);
  endtask

  // Holds rst_req for d edges; checks the edge the pin rises and the settle time.
  task automatic req_pulse(input int d, input int exp_rise, input string nm);
    int e, r, s;
    rst_req = 1;
    step(1);
    chk({nm, "_fall"}, usb_rst_n, 0);
    step(d - 1);
    rst_req = 0;
    wait_rise(100, r);
    e = d + r;
    chk({nm, "_rise_edge"}, e, exp_rise);
    wait_ready(100, s);
    chk({nm, "_settle"}, s, S);
  endtask

  initial begin
    int r, s;
    logic [7:0] rc;
    reset = 1; rst_req = 0; usb_irq_n = 1;
    step(3);
    reset = 0;

    // Power-on sequence
    step(3);  chk("po_low_e3", usb_rst_n, 0);
    step(1);  chk("po_rise_e4", usb_rst_n, 1);
    step(7);  chk("po_notready_e11", usb_ready, 0);
    step(1);  chk("po_ready_e12", usb_ready, 1);
    chk("po_busy_e12", busy, 0);
    chk("po_rcnt", reset_cnt, 1);

    // Long request: rise follows the request; short request: minimum width
    req_pulse(10, 11, "long");
    chk("long_rcnt", reset_cnt, 2);
    req_pulse(1, 5, "short");
    chk("short_rcnt", reset_cnt, 3);

    // Abort in RECOVER at its 5th edge
    rc = reset_cnt;
    rst_req = 1; step(1); rst_req = 0;
    wait_rise(100, r);
    step(4);
    rst_req = 1; step(1); rst_req = 0;
    chk("abort_low", usb_rst_n, 0);
    chk("abort_busy", busy, 1);
    chk("abort_rcnt_hold", reset_cnt, rc);
    wait_rise(100, r);
    chk("abort_pulse", r, P);
    wait_ready(100, s);
    chk("abort_settle", s, S);
    rc = rc + 8'd1;
    chk("abort_rcnt", reset_cnt, rc);

    // IRQ masking
    usb_irq_n = 0;
    step(1); chk("irq_ready", irq_out, 1);
    rst_req = 1; step(1); rst_req = 0;
    chk("irq_drop", irq_out, 0);
    s = 0;
    while (!usb_ready && s < 100) begin
      chk("irq_masked", irq_out, 0);
      step(1); s++;
    end
    chk("irq_at_ready", irq_out, 1);
    usb_irq_n = 1;
    step(1); chk("irq_release", irq_out, 0);

    // Randomized traffic, checked by the model every cycle
    for (int i = 0; i < 3000; i++) begin
      reset     = ($urandom_range(0, 299) == 0);
      rst_req   = ($urandom_range(0, 29) == 0) || (rst_req && $urandom_range(0, 3) != 0);
      usb_irq_n = $urandom_range(0, 1);
      step(1);
    end
    reset = 0; rst_req = 0; usb_irq_n = 1;
    wait_ready(100, s);

    // Reset mid-RECOVER, then counter wrap
    rst_req = 1; step(1); rst_req = 0;
    wait_rise(100, r);
    step(2);
    reset = 1; step(1); reset = 0;
    chk("mid_reset_low", usb_rst_n, 0);
    chk("mid_reset_rcnt", reset_cnt, 0);
    chk("mid_reset_busy", busy, 1);
    wait_ready(100, s);
    chk("wrap_first", reset_cnt, 1);
    for (int i = 0; i < 254; i++) begin
      rst_req = 1; step(1); rst_req = 0;
      wait_ready(100, s);
    end
    chk("wrap_255", reset_cnt, 255);
    rst_req = 1; step(1); rst_req = 0;
    wait_ready(100, s);
    chk("wrap_0", reset_cnt, 0);
    step(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
